// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with byte FIFO and drain IRQ.
// Optional even/odd parity bit when UART_TX_PARITY_EN is defined.
module mmio_uart_tx #(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd433
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:2] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ,
   output logic        tx
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
`ifdef UART_TX_PARITY_EN
   localparam int NC = 3;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   localparam int NC = 2;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
   state_t        state_q, state_d;
   logic [NC-1:0] ctrl_q;
   logic [15:0]   div_q, dl_q, dl_d, bt_q, bt_d;
   logic [2:0]    bi_q, bi_d;
   logic [7:0]    sh_q, sh_d;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wp_q, rp_q;
   logic [CW-1:0] cnt_q;
   logic          ovf_q, irq_q;
   logic [1:0]    sel;
   logic [7:0]    head;
   logic          empty, full, bit_end, can_start, pop, push, push_ok;
   logic          unused_bits;
`ifdef UART_TX_PARITY_EN
   logic          par_q, par_d;
`endif

   assign sel         = Addr[3:2];
   assign empty       = cnt_q == '0;
   assign full        = cnt_q == CW'(FIFO_DEPTH);
   assign bit_end     = bt_q == dl_q;
   assign can_start   = ctrl_q[0] & ~empty;
   assign head        = mem[rp_q];
   assign push        = WE & (sel == 2'd2);
   // a simultaneous pop frees a slot, so a push into a full FIFO still lands
   assign push_ok     = push & (~full | pop);
   assign unused_bits = ^{Addr[31:4], Din[31:16]};
   assign IRQ         = irq_q;

   always_comb begin
      state_d = state_q;
      dl_d    = dl_q;
      bt_d    = bt_q + 16'd1;
      bi_d    = bi_q;
      sh_d    = sh_q;
      pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         IDLE: begin
            bt_d    = '0;
            pop     = can_start;
            state_d = can_start ? START : IDLE;
         end
         START: if (bit_end) begin
            bt_d    = '0;
            bi_d    = '0;
            state_d = DATA;
         end
         DATA: if (bit_end) begin
            bt_d = '0;
            bi_d = bi_q + 3'd1;
            sh_d = sh_q >> 1;
`ifdef UART_TX_PARITY_EN
            state_d = (bi_q == 3'd7) ? PARITY : DATA;
`else
            state_d = (bi_q == 3'd7) ? STOP : DATA;
`endif
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (bit_end) begin
            bt_d    = '0;
            state_d = STOP;
         end
`endif
         STOP: if (bit_end) begin
            bt_d    = '0;
            pop     = can_start;
            state_d = can_start ? START : IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (pop) begin
         sh_d = head;
         dl_d = div_q;
`ifdef UART_TX_PARITY_EN
         par_d = ^head ^ ctrl_q[2];
`endif
      end
   end

`ifdef UART_TX_PARITY_EN
   assign tx = state_q == START ? 1'b0 : state_q == DATA ? sh_q[0] : state_q == PARITY ? par_q : 1'b1;
`else
   assign tx = state_q == START ? 1'b0 : state_q == DATA ? sh_q[0] : 1'b1;
`endif

   assign Dout = sel == 2'd0 ? 32'(ctrl_q) :
                 sel == 2'd1 ? {16'd0, div_q} :
                 sel == 2'd3 ? {16'd0, 8'(cnt_q), 4'd0, ovf_q, empty, full, state_q != IDLE} : '0;

   always_ff @(posedge clk)
      if (push_ok) mem[wp_q] <= Din[7:0];

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         ctrl_q  <= '0;
         div_q   <= DIV_RESET;
         dl_q    <= '0;
         bt_q    <= '0;
         bi_q    <= '0;
         sh_q    <= '0;
         wp_q    <= '0;
         rp_q    <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         irq_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         dl_q    <= dl_d;
         bt_q    <= bt_d;
         bi_q    <= bi_d;
         sh_q    <= sh_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
         if (WE && sel == 2'd0) ctrl_q <= Din[NC-1:0];
         if (WE && sel == 2'd1) div_q <= Din[15:0];
         if (push_ok) wp_q <= wp_q + PW'(1);
         if (pop) rp_q <= rp_q + PW'(1);
         cnt_q <= cnt_q + CW'(push_ok) - CW'(pop);
         if (push && !push_ok) ovf_q <= 1'b1;
         else if (WE && sel == 2'd3) ovf_q <= 1'b0;
         irq_q <= ctrl_q[1] & empty & (state_q == IDLE);
      end
   end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: randomized bench for mmio_uart_tx against a frame-timeline model,
// plus directed literal checks that pin the model.
module tb_mmio_uart_tx;
   localparam int D = 8;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] CMASK = 3'b111;
`else
   localparam logic [2:0] CMASK = 3'b011;
`endif
   logic        clk = 1'b0, reset = 1'b0, WE = 1'b0, IRQ, tx;
   logic [31:2] Addr = '0;
   logic [31:0] Din = '0, Dout;
   logic        s_rst = 1'b0, s_we = 1'b0;
   logic [1:0]  s_sel = '0;
   logic [31:0] s_din = '0;
   int          n_tests = 0, n_fail = 0;

   logic [7:0]  q[$];
   logic [2:0]  m_ctrl = '0;
   logic [15:0] m_div = 16'd433;
   logic        m_ovf = 1'b0, m_irq = 1'b0, m_act = 1'b0;
   int          m_bits[11];
   int          m_nb = 10, m_per = 1, m_off = 0, sz;
   logic        irq_n, do_pop;
   logic [7:0]  b;

   mmio_uart_tx #(.FIFO_DEPTH(D), .DIV_RESET(16'd433)) dut (
      .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din),
      .Dout(Dout), .IRQ(IRQ), .tx(tx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      s_rst <= reset;
      s_we  <= WE;
      s_sel <= Addr[3:2];
      s_din <= Din;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_dout(input logic [1:0] s);
      case (s)
         2'd0: return {29'd0, m_ctrl};
         2'd1: return {16'd0, m_div};
         2'd3: return {16'd0, 8'(q.size()), 4'd0, m_ovf, q.size() == 0, q.size() == D, m_act};
         default: return '0;
      endcase
   endfunction

   // model: a frame is a list of bits, each held m_per cycles; step once per clock edge
   initial forever begin
      @(negedge clk);
      if (!s_rst) begin
         q.delete();
         m_ctrl = '0; m_div = 16'd433; m_ovf = 1'b0; m_irq = 1'b0; m_act = 1'b0; m_off = 0;
      end else begin
         sz     = q.size();
         irq_n  = m_ctrl[1] && sz == 0 && !m_act;
         do_pop = 1'b0;
         if (m_act && m_off != m_nb * m_per - 1) m_off++;
         else begin
            m_act  = 1'b0;
            do_pop = m_ctrl[0] && sz > 0;
         end
         if (do_pop) begin
            b = q.pop_front();
            m_bits[0] = 0;
            for (int i = 0; i < 8; i++) m_bits[i+1] = int'(b[i]);
            if (CMASK[2]) begin
               m_bits[9] = int'(^b ^ m_ctrl[2]); m_bits[10] = 1; m_nb = 11;
            end else begin
               m_bits[9] = 1; m_nb = 10;
            end
            m_per = int'(m_div) + 1; m_off = 0; m_act = 1'b1;
         end
         if (s_we && s_sel == 2'd2) begin
            if (q.size() < D) q.push_back(s_din[7:0]);
            else m_ovf = 1'b1;
         end
         if (s_we && s_sel == 2'd0) m_ctrl = s_din[2:0] & CMASK;
         if (s_we && s_sel == 2'd1) m_div = s_din[15:0];
         if (s_we && s_sel == 2'd3) m_ovf = 1'b0;
         m_irq = irq_n;
      end
      chk("tx", 32'(tx), m_act ? 32'(m_bits[m_off / m_per]) : 32'd1);
      chk("irq", 32'(IRQ), 32'(m_irq));
      chk("dout", Dout, exp_dout(Addr[3:2]));
   end

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      Addr = {28'($urandom), a}; Din = d; WE = 1'b1;
      @(posedge clk); #1;
      WE = 1'b0; Din = $urandom;
   endtask

   task automatic wait_idle(input int budget, input string nm);
      int k;
      Addr = {28'($urandom), 2'd3};
      for (k = 0; k < budget; k++) begin
         @(negedge clk);
         if (Dout == 32'h4) break;
      end
      chk(nm, 32'(k < budget), 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [9:0] cap;
      int busyc, first, last, nb, irq_at, zeros, r;
      reset = 1'b0; Addr = {28'd0, 2'd3};
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("t1 status", Dout, 32'h0000_0004);
      chk("t1 tx", 32'(tx), 32'd1);
      chk("t1 irq", 32'(IRQ), 32'd0);
      Addr = {28'd0, 2'd1}; #1;
      chk("t1 div", Dout, 32'd433);
      @(posedge clk); #1;

      wr(2'd1, 32'd0); wr(2'd0, 32'd1); wr(2'd2, 32'hA5);
      Addr = {28'd0, 2'd3}; busyc = 0;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         cap[i] = tx;
         busyc += int'(Dout[0]);
      end
      @(negedge clk);
      chk("t2 frame", 32'(cap), 32'(10'b11_0100_1010));
      chk("t2 busy", 32'(busyc), 32'd10);
      chk("t2 idle", Dout, 32'h0000_0004);
      @(posedge clk); #1;

      wr(2'd0, 32'd0);
      for (int i = 0; i < 9; i++) wr(2'd2, 32'(i + 16));
      Addr = {28'd0, 2'd3}; #1;
      chk("t3 full ovf", Dout, 32'h0000_080A);
      wr(2'd3, 32'hFFFF_FFFF);
      Addr = {28'd0, 2'd3}; #1;
      chk("t3 ovf clr", Dout, 32'h0000_0802);
      wr(2'd0, 32'd1);
      wait_idle(200, "t3 drain");

      wr(2'd0, 32'd0); wr(2'd1, 32'd3); wr(2'd2, 32'h01); wr(2'd2, 32'h02); wr(2'd0, 32'd3);
      Addr = {28'd0, 2'd3};
      first = -1; last = -1; nb = 0; irq_at = -1;
      for (int i = 0; i < 300 && irq_at < 0; i++) begin
         @(negedge clk);
         if (Dout[0]) begin
            if (first < 0) first = i;
            last = i; nb++;
         end
         if (IRQ) irq_at = i;
      end
      chk("t4 busy len", 32'(nb), 32'd80);
      chk("t4 no gap", 32'(last - first + 1), 32'd80);
      chk("t4 irq rise", 32'(irq_at), 32'(last + 2));
      @(posedge clk); #1;
      wr(2'd2, 32'h55);
      @(negedge clk);
      chk("t4 irq hold", 32'(IRQ), 32'd1);
      @(negedge clk);
      chk("t4 irq fall", 32'(IRQ), 32'd0);

      @(posedge clk); #1;
      wr(2'd2, 32'hC3); wr(2'd2, 32'h3C);
      repeat (6) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1; Addr = {28'd0, 2'd3};
      @(negedge clk);
      chk("t5 tx", 32'(tx), 32'd1);
      chk("t5 status", Dout, 32'h0000_0004);
      chk("t5 irq", 32'(IRQ), 32'd0);
      zeros = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         zeros += int'(!tx);
      end
      chk("t5 no start", 32'(zeros), 32'd0);
      @(posedge clk); #1;

      for (int it = 0; it < 1500; it++) begin
         r = int'($urandom_range(0, 99));
         if (r < 35) wr(2'd2, $urandom);
         else if (r < 45) wr(2'd0, 32'($urandom_range(0, 7)) | 32'($urandom) << 3);
         else if (r < 52) wr(2'd1, 32'($urandom_range(0, 3)));
         else if (r < 56) wr(2'd3, $urandom);
         else if (r < 58) begin
            reset = 1'b0;
            @(posedge clk); #1;
            reset = 1'b1;
         end else repeat ($urandom_range(1, 8)) begin
            Addr = 30'($urandom);
            @(posedge clk); #1;
         end
      end
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
